// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose: sits between the memory-stage pipeline register and the data
// memory. Stores are queued in a small circular FIFO and written to memory
// one per cycle whenever the memory port is not needed by a load. Loads are
// answered either from the youngest matching queued store (forwarding) or by
// a direct combinational memory read.
//
// Configuration macro: STORE_FWD_EN
//   defined   - loads that match a queued store are forwarded from the FIFO.
//   undefined - no address comparators; a load stalls while any store is
//               queued and is read from memory once the FIFO has drained.
//
// Ports:
//   Clk, Rst             rising-edge clock, synchronous active-high reset
//   StoreValid/Addr/Data store request from the pipeline
//   StoreReady           store is accepted at the next edge if StoreValid
//   LoadValid/LoadAddr   load request from the pipeline
//   LoadData, LoadStall  combinational load result / hold request
//   MemWrite, MemRead    data memory strobes
//   MemAddr, MemWriteData, MemDataRead  data memory address/data
//   Full, Empty, Count   FIFO occupancy
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    StoreValid,
  input  logic [ADDR_WIDTH-1:0]   StoreAddr,
  input  logic [DATA_WIDTH-1:0]   StoreData,
  output logic                    StoreReady,
  input  logic                    LoadValid,
  input  logic [ADDR_WIDTH-1:0]   LoadAddr,
  output logic [DATA_WIDTH-1:0]   LoadData,
  output logic                    LoadStall,
  output logic                    MemWrite,
  output logic                    MemRead,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  output logic [DATA_WIDTH-1:0]   MemWriteData,
  input  logic [DATA_WIDTH-1:0]   MemDataRead,
  output logic                    Full,
  output logic                    Empty,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] entry_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_d [DEPTH];

  logic                  empty;
  logic                  full;
  logic                  store_ready;
  logic                  enq;
  logic                  mem_read;
  logic                  mem_write;
  logic                  load_stall;
  logic [DATA_WIDTH-1:0] load_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  // A load always wins over a simultaneous store.
  assign store_ready = !full && !LoadValid;
  assign enq         = StoreValid && store_ready;

`ifdef STORE_FWD_EN
  logic                  load_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0]      age_idx;

  // Walk the occupied entries from oldest to youngest so that the last match
  // seen is the youngest store to that address.
  always_comb begin
    load_hit = 1'b0;
    fwd_data = '0;
    age_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = head_q + PTR_W'(i);
      if (LoadValid && (CNT_W'(i) < count_q) &&
          (entry_addr_q[age_idx] == LoadAddr)) begin
        load_hit = 1'b1;
        fwd_data = entry_data_q[age_idx];
      end
    end
  end

  always_comb begin
    load_stall = 1'b0;
    mem_read   = LoadValid && !load_hit;
    load_data  = '0;
    if (load_hit) begin
      load_data = fwd_data;
    end else if (mem_read) begin
      load_data = MemDataRead;
    end
  end
`else
  // Without forwarding a load must wait until every older store has reached
  // memory; the drain keeps running while the load is held.
  always_comb begin
    load_stall = LoadValid && !empty;
    mem_read   = LoadValid && empty;
    load_data  = '0;
    if (mem_read) begin
      load_data = MemDataRead;
    end
  end
`endif

  // Drain the oldest entry whenever the memory port is free. Reset blocks the
  // drain so that stores pending when reset arrives never reach memory.
  assign mem_write = !Rst && !empty && !mem_read;

  // Memory bus mux: load read first, then drain, otherwise an idle zero bus.
  always_comb begin
    MemAddr      = '0;
    MemWriteData = '0;
    if (mem_read) begin
      MemAddr = LoadAddr;
    end else if (mem_write) begin
      MemAddr      = entry_addr_q[head_q];
      MemWriteData = entry_data_q[head_q];
    end
  end

  // FIFO next state: enqueue at tail, dequeue at head, count tracks the net.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    if (enq) begin
      entry_addr_d[tail_q] = StoreAddr;
      entry_data_d[tail_q] = StoreData;
      tail_d               = tail_q + PTR_W'(1);
    end
    if (mem_write) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({enq, mem_write})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: validity comes from head and count alone.
  always_ff @(posedge Clk) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

  assign StoreReady = store_ready;
  assign LoadData   = load_data;
  assign LoadStall  = load_stall;
  assign MemWrite   = mem_write;
  assign MemRead    = mem_read;
  assign Full       = full;
  assign Empty      = empty;
  assign Count      = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer (DEPTH = 4, 32-bit address and data).
// A queue-based reference model predicts every output each cycle; a table of
// burst-store vectors and a few directed sequences add hand-computed
// expectations. Honours STORE_FWD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        storeValid;
    logic [31:0] storeAddr;
    logic [31:0] storeData;
    logic [31:0] expCount;
    logic        expMemWrite;
    logic [31:0] expMemAddr;
    logic [31:0] expMemWriteData;
    logic        expStoreReady;
    logic        expFull;
  } vector_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        StoreValid;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;
  logic        StoreReady;
  logic        LoadValid;
  logic [31:0] LoadAddr;
  logic [31:0] LoadData;
  logic        LoadStall;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemDataRead;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;

  int checks   = 0;
  int failures = 0;

  entry_t      modelQ[$];
  logic [31:0] refMem [16];
  logic [31:0] physMem [16];
  logic        memLoaded = 1'b0;
  logic        sawResetWrite = 1'b0;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .StoreValid   (StoreValid),
    .StoreAddr    (StoreAddr),
    .StoreData    (StoreData),
    .StoreReady   (StoreReady),
    .LoadValid    (LoadValid),
    .LoadAddr     (LoadAddr),
    .LoadData     (LoadData),
    .LoadStall    (LoadStall),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemDataRead  (MemDataRead),
    .Full         (Full),
    .Empty        (Empty),
    .Count        (Count)
  );

  always #5 Clk = ~Clk;

  // Data memory: 16 words indexed by the low address bits, read combinationally.
  assign MemDataRead = physMem[MemAddr[3:0]];

  // Memory write port, plus a watch for the store that reset must discard.
  always @(posedge Clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 16; i++) physMem[i] <= 32'hC0DE_0000 + 32'(i);
      memLoaded <= 1'b1;
    end else if (MemWrite) begin
      physMem[MemAddr[3:0]] <= MemWriteData;
      if (MemAddr == 32'h55) sawResetWrite <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then move to the falling
  // edge where outputs are sampled.
  task automatic applyStimulus(input logic rst, input logic sv,
                               input logic [31:0] sa, input logic [31:0] sd,
                               input logic lv, input logic [31:0] la);
    Rst        = rst;
    StoreValid = sv;
    StoreAddr  = sa;
    StoreData  = sd;
    LoadValid  = lv;
    LoadAddr   = la;
    @(negedge Clk);
  endtask

  // Reference model: predicts all outputs from the queue contents and the
  // current inputs, compares, then advances the queue across the edge.
  task automatic finishCycle();
    int          n;
    logic        hit;
    logic [31:0] fwd;
    logic        expReady, expStall, expRead, expWrite;
    logic [31:0] expLoad, expAddr, expWData;
    n   = modelQ.size();
    hit = 1'b0;
    fwd = '0;
`ifdef STORE_FWD_EN
    if (LoadValid) begin
      for (int i = 0; i < n; i++) begin
        if (modelQ[i].addr == LoadAddr) begin
          hit = 1'b1;
          fwd = modelQ[i].data;
        end
      end
    end
    expStall = 1'b0;
    expRead  = LoadValid && !hit;
`else
    expStall = LoadValid && (n != 0);
    expRead  = LoadValid && (n == 0);
`endif
    expReady = (n != 4) && !LoadValid;
    expLoad  = hit ? fwd : (expRead ? refMem[LoadAddr[3:0]] : 32'h0);
    expWrite = !Rst && (n != 0) && !expRead;
    expAddr  = expRead ? LoadAddr : (expWrite ? modelQ[0].addr : 32'h0);
    expWData = expWrite ? modelQ[0].data : 32'h0;

    checkOutput("Count",        32'(Count),        32'(n));
    checkOutput("Empty",        32'(Empty),        32'(n == 0));
    checkOutput("Full",         32'(Full),         32'(n == 4));
    checkOutput("StoreReady",   32'(StoreReady),   32'(expReady));
    checkOutput("LoadStall",    32'(LoadStall),    32'(expStall));
    checkOutput("MemRead",      32'(MemRead),      32'(expRead));
    checkOutput("MemWrite",     32'(MemWrite),     32'(expWrite));
    checkOutput("MemAddr",      MemAddr,           expAddr);
    checkOutput("MemWriteData", MemWriteData,      expWData);
    checkOutput("LoadData",     LoadData,          expLoad);

    @(posedge Clk);
    if (Rst) begin
      modelQ.delete();
    end else begin
      if (expWrite) begin
        refMem[modelQ[0].addr[3:0]] = modelQ[0].data;
        void'(modelQ.pop_front());
      end
      if (StoreValid && expReady) modelQ.push_back('{addr: StoreAddr, data: StoreData});
    end
    #1;
  endtask

  vector_t burst[7];

  initial begin
    // Burst of five stores with no loads: one entry in flight, drained each
    // cycle from the cycle after the first accept, so Full never appears.
    burst[0] = '{1'b1, 32'd1, 32'hA1, 32'd0, 1'b0, 32'd0, 32'h00, 1'b1, 1'b0};
    burst[1] = '{1'b1, 32'd2, 32'hA2, 32'd1, 1'b1, 32'd1, 32'hA1, 1'b1, 1'b0};
    burst[2] = '{1'b1, 32'd3, 32'hA3, 32'd1, 1'b1, 32'd2, 32'hA2, 1'b1, 1'b0};
    burst[3] = '{1'b1, 32'd4, 32'hA4, 32'd1, 1'b1, 32'd3, 32'hA3, 1'b1, 1'b0};
    burst[4] = '{1'b1, 32'd5, 32'hA5, 32'd1, 1'b1, 32'd4, 32'hA4, 1'b1, 1'b0};
    burst[5] = '{1'b0, 32'd0, 32'h00, 32'd1, 1'b1, 32'd5, 32'hA5, 1'b1, 1'b0};
    burst[6] = '{1'b0, 32'd0, 32'h00, 32'd0, 1'b0, 32'd0, 32'h00, 1'b1, 1'b0};

    for (int i = 0; i < 16; i++) refMem[i] = 32'hC0DE_0000 + 32'(i);

    // Power-up reset for two edges; state is unknown until then.
    Rst = 1'b1; StoreValid = 1'b0; StoreAddr = '0; StoreData = '0;
    LoadValid = 1'b0; LoadAddr = '0;
    @(posedge Clk);
    @(posedge Clk);
    #1;

    // Reset state with a load presented: StoreReady must follow !LoadValid.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3);
    checkOutput("reset_Empty", 32'(Empty), 32'd1);
    checkOutput("reset_StoreReady_load", 32'(StoreReady), 32'd0);
    finishCycle();

    // Burst store table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, burst[i].storeValid, burst[i].storeAddr,
                    burst[i].storeData, 1'b0, 32'h0);
      checkOutput($sformatf("burst%0d_Count", i), 32'(Count), burst[i].expCount);
      checkOutput($sformatf("burst%0d_MemWrite", i), 32'(MemWrite), 32'(burst[i].expMemWrite));
      checkOutput($sformatf("burst%0d_MemAddr", i), MemAddr, burst[i].expMemAddr);
      checkOutput($sformatf("burst%0d_MemWriteData", i), MemWriteData, burst[i].expMemWriteData);
      checkOutput($sformatf("burst%0d_StoreReady", i), 32'(StoreReady), 32'(burst[i].expStoreReady));
      checkOutput($sformatf("burst%0d_Full", i), 32'(Full), 32'(burst[i].expFull));
      finishCycle();
    end

    // Reset with a store pending: it must never be written to memory.
    applyStimulus(1'b0, 1'b1, 32'h55, 32'hDEAD_0055, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_pending_MemWrite", 32'(MemWrite), 32'd0);
    finishCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_after_Count", 32'(Count), 32'd0);
    checkOutput("rst_after_Empty", 32'(Empty), 32'd1);
    checkOutput("rst_after_MemWrite", 32'(MemWrite), 32'd0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    finishCycle();
    checkOutput("rst_discarded_write", 32'(sawResetWrite), 32'd0);

`ifdef STORE_FWD_EN
    // Two stores to addr 7; the load must see the younger data.
    applyStimulus(1'b0, 1'b1, 32'd7, 32'h11, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 32'd7, 32'h22, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd7);
    checkOutput("fwd_LoadData", LoadData, 32'h22);
    checkOutput("fwd_MemRead", 32'(MemRead), 32'd0);
    checkOutput("fwd_MemWrite", 32'(MemWrite), 32'd1);
    finishCycle();
    // A miss with a store pending reads memory and holds the drain.
    applyStimulus(1'b0, 1'b1, 32'd7, 32'h44, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd8);
    checkOutput("miss_LoadData", LoadData, 32'hC0DE_0008);
    checkOutput("miss_MemRead", 32'(MemRead), 32'd1);
    checkOutput("miss_MemWrite", 32'(MemWrite), 32'd0);
    finishCycle();
`else
    // Load behind a pending store stalls until the store has drained.
    applyStimulus(1'b0, 1'b1, 32'd9, 32'h33, 1'b0, 32'h0);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd9);
    checkOutput("nofwd_LoadStall", 32'(LoadStall), 32'd1);
    checkOutput("nofwd_MemRead_stalled", 32'(MemRead), 32'd0);
    checkOutput("nofwd_drain_addr", MemAddr, 32'd9);
    finishCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd9);
    checkOutput("nofwd_LoadStall_done", 32'(LoadStall), 32'd0);
    checkOutput("nofwd_LoadData", LoadData, 32'h33);
    checkOutput("nofwd_MemRead", 32'(MemRead), 32'd1);
    finishCycle();
`endif

    // Randomised traffic, including aliasing addresses that differ only in
    // the upper bits and occasional mid-stream resets.
    for (int i = 0; i < 1500; i++) begin
      logic        rRst, rSv, rLv;
      logic [31:0] rSa, rLa;
      rRst = ($urandom_range(0, 63) == 0);
      rSv  = ($urandom_range(0, 2) != 0);
      rLv  = ($urandom_range(0, 3) == 0);
      rSa  = ($urandom_range(0, 3) == 0 ? 32'h1000_0000 : 32'h0) | 32'($urandom_range(0, 7));
      rLa  = ($urandom_range(0, 3) == 0 ? 32'h1000_0000 : 32'h0) | 32'($urandom_range(0, 7));
      applyStimulus(rRst, rSv, rSa, $urandom, rLv, rLa);
      finishCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
